alu_arbiter: RTL

//  Shares the single combinational ALU between two requesters, e.g. execute stage (req 0) and a

---
 rtl/alu_arbiter_pkg.sv | 38 +++
 rtl/alu_arbiter_if.sv | 30 +++
 rtl/alu_arbiter_rr_arb2.sv | 26 ++
 rtl/alu_arbiter.sv | 92 +++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter: ALU opcodes, word type, request/response structs.
package alu_arbiter_pkg;
    localparam int DW  = 32;
    localparam int SHW = 5;
    localparam int OPW = 4;

    typedef logic [DW-1:0] word_t;

    typedef enum logic [OPW-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } aluop_t;

    typedef logic arb_id_t;

    typedef struct packed {
        aluop_t           op;
        word_t            op1;
        word_t            op2;
        logic [SHW-1:0]   shamt;
    } alu_req_t;

    typedef struct packed {
        arb_id_t id;
        word_t   res;
        logic    z;
        logic    n;
        logic    v;
    } alu_rsp_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// Requester/consumer side bundle of the ALU arbiter; req_lock exists only with ALU_ARB_LOCK_EN.
interface alu_arbiter_if;
    import alu_arbiter_pkg::*;

    logic     [1:0] req_valid;
    logic     [1:0] req_ready;
    alu_req_t [1:0] req;
`ifdef ALU_ARB_LOCK_EN
    logic     [1:0] req_lock;
`endif
    logic           rsp_valid;
    logic           rsp_ready;
    alu_rsp_t       rsp;

    modport master (
`ifdef ALU_ARB_LOCK_EN
        output req_lock,
`endif
        output req_valid, req, rsp_ready,
        input  req_ready, rsp_valid, rsp
    );

    modport slave (
`ifdef ALU_ARB_LOCK_EN
        input  req_lock,
`endif
        input  req_valid, req, rsp_ready,
        output req_ready, rsp_valid, rsp
    );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: one-hot grant from valids, last winner and an optional lock.
module alu_arbiter_rr_arb2
    import alu_arbiter_pkg::*;
(
    input  logic [1:0] i_req_valid,
    input  arb_id_t    i_last_grant,
    input  logic       i_lock_held,
    input  arb_id_t    i_lock_id,
    output logic [1:0] o_grant
);
    logic [1:0] w_mask;
    logic [1:0] w_req;

    always_comb begin
        w_mask = 2'b11;
        if (i_lock_held)
            w_mask = i_lock_id ? 2'b10 : 2'b01;
        w_req = i_req_valid & w_mask;
        case (w_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with a one-entry registered response buffer.
// Optional ALU_ARB_LOCK_EN lets a requester hold the grant across a multi-op sequence.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    alu_arbiter_if.slave    bus,
    output aluop_t          o_alu_opcode,
    output word_t           o_alu_op1,
    output word_t           o_alu_op2,
    output logic [SHW-1:0]  o_alu_shamt,
    input  word_t           i_alu_res,
    input  logic            i_alu_z,
    input  logic            i_alu_n,
    input  logic            i_alu_v
);
    alu_rsp_t   r_rsp;
    logic       r_rsp_valid;
    arb_id_t    r_last_grant;
    logic       w_lock_held;
    arb_id_t    w_lock_id;
    logic [1:0] w_grant;
    arb_id_t    w_gid;
    logic       w_can_issue;
    logic       w_xfer;
    alu_req_t   w_sel;

`ifdef ALU_ARB_LOCK_EN
    logic       r_lock_held;
    arb_id_t    r_lock_id;
    assign w_lock_held = r_lock_held;
    assign w_lock_id   = r_lock_id;
`else
    assign w_lock_held = 1'b0;
    assign w_lock_id   = 1'b0;
`endif

    alu_arbiter_rr_arb2 u_arb (
        .i_req_valid  (bus.req_valid),
        .i_last_grant (r_last_grant),
        .i_lock_held  (w_lock_held),
        .i_lock_id    (w_lock_id),
        .o_grant      (w_grant)
    );

    // Draining buffer can take a new op the same cycle; nothing is accepted while in reset.
    assign w_can_issue   = (!r_rsp_valid || bus.rsp_ready) && !i_rst;
    assign w_gid         = w_grant[1];
    assign w_xfer        = w_can_issue && (w_grant != 2'b00);
    assign bus.req_ready = w_can_issue ? w_grant : 2'b00;

    assign w_sel        = bus.req[w_gid];
    assign o_alu_opcode = (w_grant != 2'b00) ? w_sel.op    : ALU_ADD;
    assign o_alu_op1    = (w_grant != 2'b00) ? w_sel.op1   : '0;
    assign o_alu_op2    = (w_grant != 2'b00) ? w_sel.op2   : '0;
    assign o_alu_shamt  = (w_grant != 2'b00) ? w_sel.shamt : '0;

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp       = r_rsp;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_valid  <= 1'b0;
            r_rsp        <= '0;
            r_last_grant <= 1'b1;
        end else if (w_xfer) begin
            r_rsp_valid  <= 1'b1;
            r_rsp        <= '{id: w_gid, res: i_alu_res, z: i_alu_z, n: i_alu_n, v: i_alu_v};
            r_last_grant <= w_gid;
        end else if (bus.rsp_ready) begin
            r_rsp_valid  <= 1'b0;
        end
    end

`ifdef ALU_ARB_LOCK_EN
    // While held only lock_id can win, so any unlocked transfer is the owner releasing.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lock_held <= 1'b0;
            r_lock_id   <= 1'b0;
        end else if (w_xfer) begin
            if (bus.req_lock[w_gid]) begin
                r_lock_held <= 1'b1;
                r_lock_id   <= w_gid;
            end else begin
                r_lock_held <= 1'b0;
            end
        end
    end
`endif
endmodule
